// File: rtl/mem_responder_pkg.sv
// Shared definitions for the chronos memory responder: command codes,
// FSM state encoding and byte-mask width.
package chronos_mem_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only updates on rd_en, so it holds across a stalled response.
module byte_en_ram
    import chronos_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [MASK_W-1:0] we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < MASK_W; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, then presents the response until the initiator takes it.
module mem_responder
    import chronos_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_cmd,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

    state_t state, state_nxt;

    logic [3:0]        cnt_p0;
    logic              cmd_p0;
    logic              err_p0;
    logic [AW-1:0]     idx_p0;
    logic [MASK_W-1:0] mask_p0;
    logic [31:0]       wdata_p0;

    logic              accept;
    logic              finish;
    logic              req_err;
    logic              ram_en;
    logic              ram_rd_en;
    logic [MASK_W-1:0] ram_we;
    logic [31:0]       ram_rdata;

    assign accept  = req_valid && req_ready;
    assign finish  = (state == BUSY) && (cnt_p0 == 4'd0);
    // Compare in 33 bits so addresses near 2^32 cannot wrap into range.
    assign req_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = BUSY;
            BUSY:    if (finish)     state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = resp_valid && err_p0;
        resp_rdata = (resp_valid && !err_p0 && (cmd_p0 == CMD_READ)) ? ram_rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= 4'd0;
        end else if (accept) begin
            cnt_p0 <= 4'(LATENCY - 1);
        end else if ((state == BUSY) && (cnt_p0 != 4'd0)) begin
            cnt_p0 <= cnt_p0 - 4'd1;
        end
    end

    // Stage p0: request fields captured at acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_p0   <= req_cmd;
            err_p0   <= req_err;
            idx_p0   <= req_addr[AW+1:2];
            mask_p0  <= req_mask;
            wdata_p0 <= req_wdata;
        end
    end

    // Storage is touched only on the BUSY->RESP edge; reset at that edge cancels it.
    assign ram_en    = finish && !err_p0 && !rst;
    assign ram_rd_en = ram_en && (cmd_p0 == CMD_READ);
    assign ram_we    = (ram_en && (cmd_p0 == CMD_WRITE)) ? mask_p0 : '0;

    byte_en_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (AW)
    ) u_ram (
        .clk  (clk),
        .rd_en(ram_rd_en),
        .we   (ram_we),
        .addr (idx_p0),
        .wdata(wdata_p0),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random
// traffic compared against a word-array reference model.
module tb_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_cmd = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_mask = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_mask  (req_mask),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    // Present a request and wait (bounded) for it to be accepted.
    task automatic issue(input logic c, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, output bit ok);
        ok = 0;
        @(negedge clk);
        req_cmd = c; req_addr = a; req_mask = m; req_wdata = d; req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        #1 req_valid = 1'b0;
    endtask

    // Count edges from acceptance to resp_valid; -1 on timeout.
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic txn(input logic c, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, output int lat,
                       output logic [31:0] rd, output logic er);
        bit ok;
        issue(c, a, m, d, ok);
        lat = -1; rd = 'x; er = 'x;
        if (ok) begin
            wait_resp(lat);
            if (lat > 0) begin
                rd = resp_rdata;
                er = resp_err;
                ack();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b e=%b d=%h want 0 0 00000000",
                     resp_valid, resp_err, resp_rdata);
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd; logic er;
        txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, rd, er);
        total++;
        if (lat !== LAT || er !== 1'b0 || rd !== 32'd0) begin
            bad++;
            $display("FAIL write_full: got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=0", lat, er, rd, LAT);
        end
        txn(1'b0, 32'h10, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (lat !== LAT || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL read_full: got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=deadbeef", lat, er, rd, LAT);
        end
        txn(1'b1, 32'h10, 4'b0001, 32'h000000AA, lat, rd, er);
        txn(1'b0, 32'h10, 4'hF, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
            bad++;
            $display("FAIL write_lane0: got rd=%h err=%b want deadbeaa 0", rd, er);
        end
        txn(1'b1, 32'h10, 4'b0000, 32'h12345678, lat, rd, er);
        total++;
        if (er !== 1'b0 || lat !== LAT) begin
            bad++;
            $display("FAIL mask_zero_err: got err=%b lat=%0d want 0 %0d", er, lat, LAT);
        end
        txn(1'b0, 32'h10, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hDEADBEAA) begin
            bad++;
            $display("FAIL mask_zero_data: got %h want deadbeaa", rd);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        logic [31:0] bad_addrs [4] = '{32'h12, 32'h1000, 32'hFFFF_FFFC, 32'h1010};
        for (int i = 0; i < 4; i++) begin
            txn(1'b0, bad_addrs[i], 4'hF, 32'h0, lat, rd, er);
            total++;
            if (er !== 1'b1 || rd !== 32'd0 || lat !== LAT) begin
                bad++;
                $display("FAIL err_read_%h: got err=%b rd=%h lat=%0d want 1 0 %0d", bad_addrs[i], er, rd, lat, LAT);
            end
            // Same bad addresses as writes: must not touch storage (0x1010 would alias 0x10).
            txn(1'b1, bad_addrs[i], 4'hF, 32'h0BAD0BAD, lat, rd, er);
            total++;
            if (er !== 1'b1 || rd !== 32'd0) begin
                bad++;
                $display("FAIL err_write_%h: got err=%b rd=%h want 1 0", bad_addrs[i], er, rd);
            end
        end
        txn(1'b0, 32'h10, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
            bad++;
            $display("FAIL err_no_modify: got %h err=%b want deadbeaa 0", rd, er);
        end
        txn(1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, lat, rd, er);
        txn(1'b0, 32'hFFC, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            bad++;
            $display("FAIL last_word: got %h err=%b want cafef00d 0", rd, er);
        end
    endtask

    task automatic test_hold();
        bit ok; int lat; int unstable = 0;
        issue(1'b0, 32'h10, 4'h0, 32'h0, ok);
        wait_resp(lat);
        total++;
        if (!ok || lat !== LAT) begin
            bad++;
            $display("FAIL hold_latency: got ok=%0d lat=%0d want 1 %0d", ok, lat, LAT);
        end
        @(negedge clk);
        req_valid = 1'b1;  // a competing request must not be taken while held
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEAA || resp_err !== 1'b0 || req_ready !== 1'b0)
                unstable++;
        end
        req_valid = 1'b0;
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", unstable);
        end
        ack();
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: got v=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; int spurious = 0; logic [31:0] rd; logic er;
        txn(1'b1, 32'h20, 4'hF, 32'h11223344, lat, rd, er);
        issue(1'b1, 32'h20, 4'hF, 32'h55667788, ok);
        @(posedge clk);          // first BUSY edge
        @(negedge clk);
        rst = 1'b1;              // covers the edge where the write would commit
        @(posedge clk);
        #1;
        if (resp_valid !== 1'b0) spurious++;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) spurious++;
        end
        total++;
        if (!ok || spurious != 0) begin
            bad++;
            $display("FAIL rst_busy_resp: got ok=%0d spurious=%0d want 1 0", ok, spurious);
        end
        txn(1'b0, 32'h20, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h11223344 || er !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy_nocommit: got %h want 11223344", rd);
        end
        // Reset while a response is pending drops it.
        issue(1'b0, 32'h20, 4'h0, 32'h0, ok);
        wait_resp(lat);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_resp: got v=%b d=%h rdy=%b want 0 0 1", resp_valid, resp_rdata, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc_cycles [$];
        int overlap = 0;
        int wrong = 0;
        @(negedge clk);
        req_cmd = 1'b0; req_addr = 32'h10; req_mask = 4'h0; req_valid = 1'b1; resp_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (req_valid && req_ready) acc_cycles.push_back(cyc);
            if (req_ready && resp_valid) overlap++;
            if (resp_valid && resp_rdata !== 32'hDEADBEAA) wrong++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        resp_ready = 1'b0;
        total++;
        if (acc_cycles.size() < 6) begin
            bad++;
            $display("FAIL b2b_count: got %0d acceptances want >= 6", acc_cycles.size());
        end
        for (int i = 1; i < acc_cycles.size(); i++) begin
            total++;
            if (acc_cycles[i] - acc_cycles[i-1] != LAT + 2) begin
                bad++;
                $display("FAIL b2b_interval_%0d: got %0d want %0d", i, acc_cycles[i] - acc_cycles[i-1], LAT + 2);
            end
        end
        total++;
        if (overlap != 0 || wrong != 0) begin
            bad++;
            $display("FAIL b2b_overlap: got overlap=%0d wrong_data=%0d want 0 0", overlap, wrong);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic er;
        logic c; logic [31:0] a; logic [3:0] m; logic [31:0] d;
        logic exp_err; logic [31:0] exp_rd; int w;
        for (int k = 0; k < 60; k++) begin
            c = 1'($urandom_range(0, 1));
            m = 4'($urandom);
            d = $urandom;
            case ($urandom_range(0, 9))
                0:       a = 32'h100 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
                1:       a = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
                default: a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
            endcase
            exp_err = (a % 4 != 0) || (64'(a) >= 64'(4 * DEPTH));
            exp_rd  = 32'd0;
            w = int'(a / 4) % DEPTH;
            if (!exp_err && c == 1'b1) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) model[w][8*b +: 8] = d[8*b +: 8];
                if (m == 4'hF) known[w] = 1;
            end else if (!exp_err) begin
                exp_rd = model[w];
            end
            txn(c, a, m, d, lat, rd, er);
            total++;
            if (lat !== LAT || er !== exp_err ||
                ((exp_err || c == 1'b1 || known[w]) && rd !== exp_rd)) begin
                bad++;
                $display("FAIL rand_%0d cmd=%b addr=%h: got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                         k, c, a, lat, er, rd, LAT, exp_err, exp_rd);
            end
            if (!exp_err && c == 1'b0 && !known[w]) begin
                model[w] = rd;  // adopt the power-up contents once observed
                known[w] = 1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            known[i] = 0;
        end
        test_reset();
        test_basic();
        test_errors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
